// File: rtl/video_stitch_pkg.sv
// Shared types and constants for the CMOS-to-AXI pixel packing path.
package video_stitch_pkg;
    localparam int PIX_SLOT_W   = 32;
    localparam int PIX_PER_WORD = 128 / PIX_SLOT_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } pack_state_t;
endpackage

// File: rtl/cmos_pixel_packer_if.sv
// Packed-word write bus from the pixel packer towards the AXI write FIFO.
interface cmos_pixel_packer_if #(
    parameter int DATA_W = 128
) ();
    // A word transfers on every clock edge where wr_valid & wr_ready; wr_data is
    // stable while wr_valid is high and not accepted, and ready may depend on nothing from the master.
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/pack_out_fifo2.sv
// Two-entry FIFO; the head entry is a register that drives the output bus directly.
module pack_out_fifo2 #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] data,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   count_q;
    logic         pop_ok;

    assign data   = head_q;
    assign empty  = (count_q == 2'd0);
    assign full   = (count_q == 2'd2);
    assign pop_ok = pop & ~empty;

    // A push into a full buffer without a pop is ignored here; the caller flags it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q  <= push_data;
                        count_q <= 2'd1;
                    end else if (count_q == 2'd1) begin
                        tail_q  <= push_data;
                        count_q <= 2'd2;
                    end
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/cmos_pixel_packer.sv
// Packs RGB888 CMOS pixels four to a 128-bit word, frames images and flags
// line-length errors and output overflow (the CMOS source cannot be stalled).
module cmos_pixel_packer
    import video_stitch_pkg::*;
#(
    parameter int PIX_WIDTH      = 24,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int IMG_HDISP      = 1280,
    parameter int IMG_VDISP      = 720,
    parameter bit VSYNC_POL      = 1'b1
) (
    input  logic                 cmos_clk,
    input  logic                 rst,
    input  logic                 cmos_vsync,
    input  logic                 cmos_href,
    input  logic                 cmos_clken,
    input  logic [PIX_WIDTH-1:0] cmos_data,
    cmos_pixel_packer_if.master  wr,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 line_err,
    output logic                 overflow,
    output pack_state_t          state_dbg
);
    localparam int LANES = AXI_DATA_WIDTH / PIX_SLOT_W;
    localparam int LW    = $clog2(LANES);
    localparam int PW    = $clog2(IMG_HDISP + 1);
    localparam int VW    = $clog2(IMG_VDISP + 1);

    pack_state_t               state_q, state_d;
    logic                      vs_q, href_q;
    logic                      vs_edge, href_fall, pix_fire, last_lane, flush, push;
    logic [LW-1:0]             lane_q;
    logic [AXI_DATA_WIDTH-1:0] pack_q, word, fifo_data;
    logic [PW-1:0]             pix_cnt;
    logic [VW-1:0]             line_cnt, line_nxt;
    logic                      fifo_empty, fifo_full, fifo_drop;

    assign vs_edge   = VSYNC_POL ? (cmos_vsync & ~vs_q) : (~cmos_vsync & vs_q);
    assign href_fall = href_q & ~cmos_href;
    assign pix_fire  = (state_q == ACTIVE) & ~vs_edge & cmos_href & cmos_clken;
    assign last_lane = (lane_q == LW'(LANES - 1));
    assign flush     = (state_q == ACTIVE) & ~vs_edge & href_fall & (lane_q != '0);
    assign push      = (pix_fire & last_lane) | flush;
    assign line_nxt  = (line_cnt == '1) ? line_cnt : line_cnt + 1'b1;
    assign fifo_drop = push & fifo_full & ~(wr.wr_valid & wr.wr_ready);

    // Slots not yet written stay zero because pack_q is cleared after every push.
    always_comb begin
        word = pack_q;
        if (pix_fire) begin
            word[lane_q*PIX_SLOT_W +: PIX_SLOT_W] = PIX_SLOT_W'(cmos_data);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            ACTIVE:  if (href_fall && line_nxt == VW'(IMG_VDISP)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (vs_edge) state_d = ACTIVE;
    end

    always_ff @(posedge cmos_clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge cmos_clk or posedge rst) begin
        if (rst) begin
            vs_q        <= 1'b0;
            href_q      <= 1'b0;
            frame_start <= 1'b0;
            lane_q      <= '0;
            pack_q      <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            line_err    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            vs_q        <= cmos_vsync;
            href_q      <= cmos_href;
            frame_start <= vs_edge;
            if (vs_edge) begin
                lane_q   <= '0;
                pack_q   <= '0;
                pix_cnt  <= '0;
                line_cnt <= '0;
                line_err <= 1'b0;
            end else begin
                if (pix_fire) begin
                    lane_q <= last_lane ? '0 : lane_q + 1'b1;
                    pack_q <= last_lane ? '0 : word;
                    if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
                end
                if (state_q == ACTIVE && href_fall) begin
                    line_cnt <= line_nxt;
                    pix_cnt  <= '0;
                    lane_q   <= '0;
                    pack_q   <= '0;
                    if (pix_cnt != PW'(IMG_HDISP)) line_err <= 1'b1;
                end
            end
            // A drop in the same cycle as a new frame still reports.
            if (fifo_drop)    overflow <= 1'b1;
            else if (vs_edge) overflow <= 1'b0;
        end
    end

    pack_out_fifo2 #(.W(AXI_DATA_WIDTH)) u_fifo (
        .clk       (cmos_clk),
        .rst       (rst),
        .push      (push),
        .push_data (word),
        .pop       (wr.wr_ready),
        .data      (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign wr.wr_data  = fifo_data;
    assign wr.wr_valid = ~fifo_empty;
    assign frame_done  = (state_q == DONE);
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Directed scoreboard bench for cmos_pixel_packer with IMG_HDISP=6, IMG_VDISP=3.
module tb_cmos_pixel_packer;
    import video_stitch_pkg::*;

    logic        cmos_clk;
    logic        rst;
    logic        cmos_vsync, cmos_href, cmos_clken;
    logic [23:0] cmos_data;
    logic        frame_start, frame_done, line_err, overflow;
    pack_state_t state_dbg;

    cmos_pixel_packer_if #(.DATA_W(128)) bus ();

    cmos_pixel_packer #(
        .PIX_WIDTH      (24),
        .AXI_DATA_WIDTH (128),
        .IMG_HDISP      (6),
        .IMG_VDISP      (3),
        .VSYNC_POL      (1'b1)
    ) dut (
        .cmos_clk    (cmos_clk),
        .rst         (rst),
        .cmos_vsync  (cmos_vsync),
        .cmos_href   (cmos_href),
        .cmos_clken  (cmos_clken),
        .cmos_data   (cmos_data),
        .wr          (bus),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .line_err    (line_err),
        .overflow    (overflow),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial cmos_clk = 1'b0;
    always #5 cmos_clk = ~cmos_clk;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge cmos_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pix(input logic [23:0] d);
        cmos_href  = 1'b1;
        cmos_clken = 1'b1;
        cmos_data  = d;
        tick();
    endtask

    task automatic end_line();
        cmos_href  = 1'b0;
        cmos_clken = 1'b0;
        tick();
    endtask

    // scoreboard monitor
    always @(negedge cmos_clk) begin
        if (!rst && bus.wr_valid && bus.wr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h expected none", bus.wr_data);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (bus.wr_data !== e) begin
                    errors++;
                    $display("FAIL word: got %h expected %h", bus.wr_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_clken = 1'b0;
        cmos_data = '0; bus.wr_ready = 1'b1;
        idle(2);
        @(negedge cmos_clk);
        check("rst_wr_data", bus.wr_data, '0);
        check("rst_wr_valid", 128'(bus.wr_valid), 0);
        check("rst_frame_start", 128'(frame_start), 0);
        check("rst_frame_done", 128'(frame_done), 0);
        check("rst_line_err", 128'(line_err), 0);
        check("rst_overflow", 128'(overflow), 0);
        check("rst_state", 128'(state_dbg), 128'(IDLE));
        rst = 1'b0;
        tick();

        // frame A: start pulse one cycle after the vsync edge
        cmos_vsync = 1'b1;
        @(negedge cmos_clk);
        check("fs_before", 128'(frame_start), 0);
        @(negedge cmos_clk);
        check("fs_pulse", 128'(frame_start), 1);
        check("state_active", 128'(state_dbg), 128'(ACTIVE));
        @(negedge cmos_clk);
        check("fs_after", 128'(frame_start), 0);
        cmos_vsync = 1'b0;

        // line 1: six pixels, full word then half word
        exp_q.push_back({32'h00040506, 32'h00030405, 32'h00020304, 32'h00010203});
        exp_q.push_back({64'h0, 32'h00060708, 32'h00050607});
        pix(24'h010203); pix(24'h020304); pix(24'h030405);
        @(negedge cmos_clk);
        check("latency_pre", 128'(bus.wr_valid), 0);
        pix(24'h040506);
        @(negedge cmos_clk);
        check("latency_post", 128'(bus.wr_valid), 1);
        pix(24'h050607); pix(24'h060708);
        end_line();
        idle(3);
        check("line1_err", 128'(line_err), 0);

        // line 2: five pixels -> short line
        exp_q.push_back({32'h00444444, 32'h00333333, 32'h00222222, 32'h00111111});
        exp_q.push_back({96'h0, 32'h00555555});
        pix(24'h111111); pix(24'h222222); pix(24'h333333); pix(24'h444444); pix(24'h555555);
        end_line();
        idle(3);
        check("line2_err", 128'(line_err), 1);

        // line 3: last line of the frame
        exp_q.push_back({32'h00A00003, 32'h00A00002, 32'h00A00001, 32'h00A00000});
        exp_q.push_back({64'h0, 32'h00A00005, 32'h00A00004});
        for (int i = 0; i < 6; i++) pix(24'hA00000 + 24'(i));
        end_line();
        check("frame_done_pulse", 128'(frame_done), 1);
        tick();
        check("frame_done_end", 128'(frame_done), 0);
        check("state_idle", 128'(state_dbg), 128'(IDLE));
        check("line_err_held", 128'(line_err), 1);
        idle(3);

        // frame B: stalled sink, three words, third one dropped
        bus.wr_ready = 1'b0;
        cmos_vsync   = 1'b1;
        tick();
        check("fsB_pulse", 128'(frame_start), 1);
        check("fsB_line_err_clr", 128'(line_err), 0);
        check("fsB_overflow", 128'(overflow), 0);
        cmos_vsync = 1'b0;
        tick();
        check("fsB_after", 128'(frame_start), 0);
        exp_q.push_back({32'h00B00003, 32'h00B00002, 32'h00B00001, 32'h00B00000});
        exp_q.push_back({32'h00B00007, 32'h00B00006, 32'h00B00005, 32'h00B00004});
        for (int i = 0; i < 12; i++) pix(24'hB00000 + 24'(i));
        end_line();
        idle(2);
        check("ovf_set", 128'(overflow), 1);
        check("ovf_valid", 128'(bus.wr_valid), 1);
        check("ovf_head", bus.wr_data, {32'h00B00003, 32'h00B00002, 32'h00B00001, 32'h00B00000});
        check("long_line_err", 128'(line_err), 1);
        bus.wr_ready = 1'b1;
        idle(4);
        check("drained", 128'(bus.wr_valid), 0);

        // reset mid-line with two lanes filled
        pix(24'hD00001); pix(24'hD00002);
        #2;
        rst = 1'b1;
        #1;
        check("arst_wr_valid", 128'(bus.wr_valid), 0);
        check("arst_wr_data", bus.wr_data, '0);
        check("arst_overflow", 128'(overflow), 0);
        check("arst_line_err", 128'(line_err), 0);
        check("arst_frame_done", 128'(frame_done), 0);
        check("arst_state", 128'(state_dbg), 128'(IDLE));
        cmos_clken = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(3);
        cmos_href = 1'b0;
        idle(4);
        check("no_flush", 128'(bus.wr_valid), 0);

        // frame C: packing restarts at lane 0
        cmos_vsync = 1'b1;
        tick();
        check("fsC_pulse", 128'(frame_start), 1);
        cmos_vsync = 1'b0;
        exp_q.push_back({32'h00C00004, 32'h00C00003, 32'h00C00002, 32'h00C00001});
        pix(24'hC00001); pix(24'hC00002); pix(24'hC00003); pix(24'hC00004);
        end_line();
        idle(4);
        check("fsC_state", 128'(state_dbg), 128'(ACTIVE));

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("queue_empty", 128'(exp_q.size()), 0);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
